// File: rtl/ship_pkg.sv
// Shared types, key codes and default playfield geometry for the player ship block.
package ship_pkg;

  typedef enum logic [1:0] {
    ALIVE   = 2'd0,
    RESPAWN = 2'd1,
    DEAD    = 2'd2
  } ship_state_t;

  localparam logic [7:0] KEY_A       = 8'h04;
  localparam logic [7:0] KEY_D       = 8'h07;
  localparam logic [7:0] KEY_W       = 8'h1A;
  localparam logic [7:0] KEY_S       = 8'h16;
  localparam logic [7:0] KEY_RESTART = 8'h28;

  localparam int DEF_X_MIN       = 9;
  localparam int DEF_X_MAX       = 630;
  localparam int DEF_Y_MIN       = 32;
  localparam int DEF_Y_MAX       = 473;
  localparam int DEF_X_START     = 320;
  localparam int DEF_Y_START     = 450;
  localparam int DEF_HALF_W      = 17;
  localparam int DEF_HALF_W_MOVE = 14;
  localparam int DEF_HALF_H      = 16;

endpackage

// File: rtl/ship_collide.sv
// Combinational AABB overlap of the ship against every enemy slot; lowest colliding index wins.
module ship_collide #(
  parameter int OBJ_NUM = 4,
  parameter int IDX_W   = 2
) (
  input  logic [9:0]         ship_x,
  input  logic [9:0]         ship_y,
  input  logic [9:0]         ship_w,
  input  logic [9:0]         ship_h,
  input  logic [9:0]         enemy_x    [OBJ_NUM],
  input  logic [9:0]         enemy_y    [OBJ_NUM],
  input  logic [9:0]         enemy_size [OBJ_NUM],
  input  logic [OBJ_NUM-1:0] enemy_alive,
  output logic               any_hit,
  output logic [IDX_W-1:0]   hit_idx
);

  logic [OBJ_NUM-1:0] hit_vec;

  // Half-extents are moved to the enemy side of each inequality so nothing can underflow.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < OBJ_NUM; i++) begin
      hit_vec[i] = enemy_alive[i]
        && ({2'b00, ship_x} <= {2'b00, enemy_x[i]} + {2'b00, enemy_size[i]} + {2'b00, ship_w})
        && ({2'b00, ship_y} <= {2'b00, enemy_y[i]} + {2'b00, enemy_size[i]} + {2'b00, ship_h})
        && ({2'b00, ship_x} + {2'b00, ship_w} > {2'b00, enemy_x[i]})
        && ({2'b00, ship_y} + {2'b00, ship_h} > {2'b00, enemy_y[i]});
    end
  end

  always_comb begin
    any_hit = 1'b0;
    hit_idx = '0;
    for (int i = OBJ_NUM - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        any_hit = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/player_ship_ctrl.sv
// Player ship controller: keyboard motion with clamping, enemy collision, lives and
// invulnerable respawn, game-over with restart key. All state advances on frame_clk.
module player_ship_ctrl
  import ship_pkg::*;
#(
  parameter int OBJ_NUM       = 4,
  parameter int KEY_SLOTS     = 3,
  parameter int STEP          = 3,
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int X_MIN         = DEF_X_MIN,
  parameter int X_MAX         = DEF_X_MAX,
  parameter int Y_MIN         = DEF_Y_MIN,
  parameter int Y_MAX         = DEF_Y_MAX,
  parameter int X_START       = DEF_X_START,
  parameter int Y_START       = DEF_Y_START,
  parameter int HALF_W        = DEF_HALF_W,
  parameter int HALF_W_MOVE   = DEF_HALF_W_MOVE,
  parameter int HALF_H        = DEF_HALF_H,
  parameter int LIVES_W       = $clog2(LIVES_INIT + 1),
  parameter int IDX_W         = (OBJ_NUM > 1) ? $clog2(OBJ_NUM) : 1
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic [8*KEY_SLOTS-1:0] keycode,
  input  logic [9:0]             enemy_x    [OBJ_NUM],
  input  logic [9:0]             enemy_y    [OBJ_NUM],
  input  logic [9:0]             enemy_size [OBJ_NUM],
  input  logic [OBJ_NUM-1:0]     enemy_alive,
  output logic [9:0]             ship_x,
  output logic [9:0]             ship_y,
  output logic [9:0]             ship_w,
  output logic [9:0]             ship_h,
  output logic                   left_move,
  output logic                   right_move,
  output logic [LIVES_W-1:0]     lives,
  output logic                   invuln,
  output logic                   hit_valid,
  output logic [IDX_W-1:0]       hit_idx,
  output logic                   game_over
);

  localparam int CNT_W = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;

  localparam logic signed [10:0] X_LO = 11'(X_MIN + HALF_W_MOVE);
  localparam logic signed [10:0] X_HI = 11'(X_MAX - HALF_W_MOVE);
  localparam logic signed [10:0] Y_LO = 11'(Y_MIN + HALF_H);
  localparam logic signed [10:0] Y_HI = 11'(Y_MAX - HALF_H);

  ship_state_t        state_q, state_d;
  logic [9:0]         ship_x_q, ship_x_d;
  logic [9:0]         ship_y_q, ship_y_d;
  logic               left_move_q, left_move_d;
  logic               right_move_q, right_move_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hit_valid_q, hit_valid_d;
  logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;

  logic               key_a, key_d, key_w, key_s, key_restart;
  logic               mv_left, mv_right, mv_up, mv_down;
  logic signed [10:0] nx, ny;
  logic               any_hit;
  logic [IDX_W-1:0]   col_idx;

  assign ship_x     = ship_x_q;
  assign ship_y     = ship_y_q;
  assign ship_w     = (left_move_q | right_move_q) ? 10'(HALF_W_MOVE) : 10'(HALF_W);
  assign ship_h     = 10'(HALF_H);
  assign left_move  = left_move_q;
  assign right_move = right_move_q;
  assign lives      = lives_q;
  assign invuln     = (state_q == RESPAWN);
  assign hit_valid  = hit_valid_q;
  assign hit_idx    = hit_idx_q;
  assign game_over  = (state_q == DEAD);

  ship_collide #(
    .OBJ_NUM (OBJ_NUM),
    .IDX_W   (IDX_W)
  ) u_collide (
    .ship_x      (ship_x_q),
    .ship_y      (ship_y_q),
    .ship_w      (ship_w),
    .ship_h      (ship_h),
    .enemy_x     (enemy_x),
    .enemy_y     (enemy_y),
    .enemy_size  (enemy_size),
    .enemy_alive (enemy_alive),
    .any_hit     (any_hit),
    .hit_idx     (col_idx)
  );

  always_comb begin
    key_a       = 1'b0;
    key_d       = 1'b0;
    key_w       = 1'b0;
    key_s       = 1'b0;
    key_restart = 1'b0;
    for (int s = 0; s < KEY_SLOTS; s++) begin
      if (keycode[8*s +: 8] == KEY_A)       key_a       = 1'b1;
      if (keycode[8*s +: 8] == KEY_D)       key_d       = 1'b1;
      if (keycode[8*s +: 8] == KEY_W)       key_w       = 1'b1;
      if (keycode[8*s +: 8] == KEY_S)       key_s       = 1'b1;
      if (keycode[8*s +: 8] == KEY_RESTART) key_restart = 1'b1;
    end
    mv_left  = key_a & ~key_d;
    mv_right = key_d & ~key_a;
    mv_up    = key_w & ~key_s;
    mv_down  = key_s & ~key_w;
  end

  // Candidate next position with opposite-key cancellation and playfield clamp.
  always_comb begin
    nx = $signed({1'b0, ship_x_q});
    ny = $signed({1'b0, ship_y_q});
    if (mv_left)       nx = nx - $signed(11'(STEP));
    else if (mv_right) nx = nx + $signed(11'(STEP));
    if (mv_up)         ny = ny - $signed(11'(STEP));
    else if (mv_down)  ny = ny + $signed(11'(STEP));
    if (nx < X_LO)      nx = X_LO;
    else if (nx > X_HI) nx = X_HI;
    if (ny < Y_LO)      ny = Y_LO;
    else if (ny > Y_HI) ny = Y_HI;
  end

  always_comb begin
    state_d      = state_q;
    ship_x_d     = ship_x_q;
    ship_y_d     = ship_y_q;
    left_move_d  = left_move_q;
    right_move_d = right_move_q;
    lives_d      = lives_q;
    cnt_d        = cnt_q;
    hit_valid_d  = 1'b0;
    hit_idx_d    = hit_idx_q;

    case (state_q)
      ALIVE: begin
        if (any_hit) begin
          hit_valid_d  = 1'b1;
          hit_idx_d    = col_idx;
          lives_d      = lives_q - LIVES_W'(1);
          left_move_d  = 1'b0;
          right_move_d = 1'b0;
          if (lives_q == LIVES_W'(1)) begin
            state_d = DEAD;
          end else begin
            state_d  = RESPAWN;
            ship_x_d = 10'(X_START);
            ship_y_d = 10'(Y_START);
            cnt_d    = CNT_W'(INVULN_FRAMES - 1);
          end
        end else begin
          ship_x_d     = 10'(nx);
          ship_y_d     = 10'(ny);
          left_move_d  = mv_left;
          right_move_d = mv_right;
        end
      end

      RESPAWN: begin
        ship_x_d     = 10'(nx);
        ship_y_d     = 10'(ny);
        left_move_d  = mv_left;
        right_move_d = mv_right;
        if (cnt_q == '0) state_d = ALIVE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      DEAD: begin
        left_move_d  = 1'b0;
        right_move_d = 1'b0;
        lives_d      = '0;
        if (key_restart) begin
          state_d  = ALIVE;
          ship_x_d = 10'(X_START);
          ship_y_d = 10'(Y_START);
          lives_d  = LIVES_W'(LIVES_INIT);
          cnt_d    = '0;
          hit_idx_d = '0;
        end
      end

      default: state_d = ALIVE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= ALIVE;
      ship_x_q     <= 10'(X_START);
      ship_y_q     <= 10'(Y_START);
      left_move_q  <= 1'b0;
      right_move_q <= 1'b0;
      lives_q      <= LIVES_W'(LIVES_INIT);
      cnt_q        <= '0;
      hit_valid_q  <= 1'b0;
      hit_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      ship_x_q     <= ship_x_d;
      ship_y_q     <= ship_y_d;
      left_move_q  <= left_move_d;
      right_move_q <= right_move_d;
      lives_q      <= lives_d;
      cnt_q        <= cnt_d;
      hit_valid_q  <= hit_valid_d;
      hit_idx_q    <= hit_idx_d;
    end
  end

endmodule
